// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bit-reversal reorder stage: FSM states, bank flags, index helper.
// No latency or backpressure of its own; types and a pure function only.
package fft_pkg;

    localparam int MAX_LAYER = 12;

    localparam logic BANK_EMPTY = 1'b0;
    localparam logic BANK_FULL  = 1'b1;

    typedef enum logic {
        WR_IDLE,
        WR_FILL
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    // Reverses the low 'layer' bits of idx; higher result bits are zero.
    function automatic logic [MAX_LAYER-1:0] bitrev(input logic [MAX_LAYER-1:0] idx, input int layer);
        logic [MAX_LAYER-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LAYER; i++) begin
            if (i < layer) begin
                r[i] = idx[layer-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port sample buffer holding both ping-pong banks, addressed {bank, idx}.
// Latency: 1 clk registered read; the read register holds its value when rd_en is low.
// No backpressure: the caller guarantees a bank is never read and written at once.
module fft_reorder_ram #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the stage output register, so it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order using two ping-pong banks.
// Latency: last input sample in cycle T -> out_start in T+2, burst of N contiguous samples.
// No input backpressure: a frame arriving with no free bank is discarded (frame_drop).
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int LAYER  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_img,
    input  logic              in_valid,
    input  logic              in_start,
    input  logic              in_end,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_img,
    output logic              out_valid,
    output logic              out_start,
    output logic              out_end,
    output logic              frame_err,
    output logic              frame_drop
);

    localparam int AW = LAYER + 1;
    localparam logic [LAYER-1:0] IDX_LAST = {LAYER{1'b1}};
    localparam logic [LAYER-1:0] IDX_ONE  = {{(LAYER-1){1'b0}}, 1'b1};

    wr_state_t        wr_state, wr_state_nxt;
    rd_state_t        rd_state, rd_state_nxt;
    logic [LAYER-1:0] wr_idx, wr_idx_nxt, wr_lidx;
    logic [LAYER-1:0] rd_idx, rd_idx_nxt, rd_lidx;
    logic             wr_bank, rd_bank;
    logic [1:0]       bank_state;
    logic             wr_en, wr_close, err_set, drop_set;
    logic             rd_issue, rd_done;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [2*DATA_W-1:0] rd_data;

    // State registers and bank bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state   <= WR_IDLE;
            rd_state   <= RD_IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_state <= {BANK_EMPTY, BANK_EMPTY};
            out_valid  <= 1'b0;
            out_start  <= 1'b0;
            out_end    <= 1'b0;
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            wr_state   <= wr_state_nxt;
            rd_state   <= rd_state_nxt;
            wr_idx     <= wr_idx_nxt;
            rd_idx     <= rd_idx_nxt;
            if (wr_close) begin
                wr_bank             <= ~wr_bank;
                bank_state[wr_bank] <= BANK_FULL;
            end
            if (rd_done) begin
                rd_bank             <= ~rd_bank;
                bank_state[rd_bank] <= BANK_EMPTY;
            end
            out_valid  <= rd_issue;
            out_start  <= rd_issue && (rd_lidx == '0);
            out_end    <= rd_issue && (rd_lidx == IDX_LAST);
            frame_err  <= err_set;
            frame_drop <= drop_set;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (in_valid && in_start && !in_end && bank_state[wr_bank] == BANK_EMPTY) begin
                    wr_state_nxt = WR_FILL;
                end
            end
            WR_FILL: begin
                if (in_valid) begin
                    if (in_start) begin
                        wr_state_nxt = in_end ? WR_IDLE : WR_FILL;
                    end else if (in_end || wr_idx == IDX_LAST) begin
                        wr_state_nxt = WR_IDLE;
                    end
                end
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // A restart mid-frame reuses the same bank; a short frame leaves the bank EMPTY.
    always_comb begin
        wr_en      = 1'b0;
        wr_close   = 1'b0;
        err_set    = 1'b0;
        drop_set   = 1'b0;
        wr_lidx    = '0;
        wr_idx_nxt = wr_idx;
        case (wr_state)
            WR_IDLE: begin
                if (in_valid && in_start) begin
                    if (bank_state[wr_bank] != BANK_EMPTY) begin
                        drop_set = 1'b1;
                    end else if (in_end) begin
                        err_set = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_idx_nxt = IDX_ONE;
                    end
                end
            end
            WR_FILL: begin
                if (in_valid) begin
                    if (in_start) begin
                        err_set = 1'b1;
                        if (!in_end) begin
                            wr_en      = 1'b1;
                            wr_idx_nxt = IDX_ONE;
                        end else begin
                            wr_idx_nxt = '0;
                        end
                    end else if (wr_idx == IDX_LAST) begin
                        wr_en      = 1'b1;
                        wr_lidx    = wr_idx;
                        wr_close   = 1'b1;
                        wr_idx_nxt = '0;
                    end else if (in_end) begin
                        err_set    = 1'b1;
                        wr_idx_nxt = '0;
                    end else begin
                        wr_en      = 1'b1;
                        wr_lidx    = wr_idx;
                        wr_idx_nxt = wr_idx + IDX_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (bank_state[rd_bank] == BANK_FULL) rd_state_nxt = RD_READ;
            RD_READ: if (rd_idx == IDX_LAST) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Releasing the bank on the addr N-1 cycle lets a back-to-back frame claim it next cycle.
    always_comb begin
        rd_issue   = 1'b0;
        rd_done    = 1'b0;
        rd_lidx    = '0;
        rd_idx_nxt = rd_idx;
        case (rd_state)
            RD_IDLE: begin
                if (bank_state[rd_bank] == BANK_FULL) begin
                    rd_issue   = 1'b1;
                    rd_idx_nxt = IDX_ONE;
                end
            end
            RD_READ: begin
                rd_issue = 1'b1;
                rd_lidx  = rd_idx;
                if (rd_idx == IDX_LAST) begin
                    rd_done    = 1'b1;
                    rd_idx_nxt = '0;
                end else begin
                    rd_idx_nxt = rd_idx + IDX_ONE;
                end
            end
            default: ;
        endcase
    end

    assign wr_addr = {wr_bank, LAYER'(bitrev(MAX_LAYER'(wr_lidx), LAYER))};
    assign rd_addr = {rd_bank, rd_lidx};

    fft_reorder_ram #(
        .ADDR_W (AW),
        .WIDTH  (2*DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({in_real, in_img}),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign out_real = rd_data[2*DATA_W-1:DATA_W];
    assign out_img  = rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder (LAYER=3): directed frame scenarios with random payloads,
// compared against a frame-level reorder model.
module tb_fft_bitrev_reorder;

    localparam int LAYER = 3;
    localparam int N     = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_real, in_img;
    logic          in_valid, in_start, in_end;
    logic [DW-1:0] out_real, out_img;
    logic          out_valid, out_start, out_end, frame_err, frame_drop;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.LAYER(LAYER), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_real    (in_real),
        .in_img     (in_img),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .in_end     (in_end),
        .out_real   (out_real),
        .out_img    (out_img),
        .out_valid  (out_valid),
        .out_start  (out_start),
        .out_end    (out_end),
        .frame_err  (frame_err),
        .frame_drop (frame_drop)
    );

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        st;
        logic        en;
        logic [31:0] cyc;
    } smp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    smp_t        got_q[$];
    smp_t        exp_q[$];
    int          got_rd = 0;
    int          err_seen = 0;
    int          drop_seen = 0;
    int          stray_seen = 0;
    logic [31:0] fr_re[N];
    logic [31:0] fr_im[N];
    logic [31:0] last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        smp_t s;
        if (out_valid) begin
            s.re = out_real; s.im = out_img; s.st = out_start; s.en = out_end; s.cyc = cyc;
            got_q.push_back(s);
        end
        if (frame_err) err_seen++;
        if (frame_drop) drop_seen++;
        if (!out_valid && (out_start || out_end)) stray_seen++;
    end

    // Natural index j holds the input sample whose position is j with its bits reversed.
    function automatic int rev(input int j);
        int r = 0;
        int x = j;
        for (int b = 0; b < LAYER; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [31:0] re, input logic [31:0] im);
        in_valid = v; in_start = s; in_end = e; in_real = re; in_img = im;
        @(posedge clk);
        #1;
        if (v) last_acc = cyc;
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = $urandom;
            fr_im[i] = $urandom;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, i == 0, i == N-1, fr_re[i], fr_im[i]);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic expect_frame();
        smp_t s;
        for (int j = 0; j < N; j++) begin
            s.re = fr_re[rev(j)]; s.im = fr_im[rev(j)];
            s.st = (j == 0); s.en = (j == N-1); s.cyc = 0;
            exp_q.push_back(s);
        end
    endtask

    task automatic drain(input string tag, input bit contiguous);
        int   t = 0;
        smp_t g;
        while ((got_q.size() - got_rd) < exp_q.size() && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, " count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (got_rd + k < got_q.size()) begin
                g = got_q[got_rd + k];
                check($sformatf("%s re[%0d]", tag, k), 64'(g.re), 64'(exp_q[k].re));
                check($sformatf("%s im[%0d]", tag, k), 64'(g.im), 64'(exp_q[k].im));
                check($sformatf("%s start[%0d]", tag, k), 64'(g.st), 64'(exp_q[k].st));
                check($sformatf("%s end[%0d]", tag, k), 64'(g.en), 64'(exp_q[k].en));
                if (contiguous && k > 0)
                    check($sformatf("%s gap[%0d]", tag, k), 64'(g.cyc), 64'(got_q[got_rd+k-1].cyc + 1));
            end
        end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int base, e0, d0;
        logic [31:0] first_cyc, end_cyc;

        rst = 1'b1;
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_real = '0; in_img = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_start", 64'(out_start), 64'd0);
        check("rst out_end", 64'(out_end), 64'd0);
        check("rst out_real", 64'(out_real), 64'd0);
        check("rst out_img", 64'(out_img), 64'd0);
        check("rst frame_err", 64'(frame_err), 64'd0);
        check("rst frame_drop", 64'(frame_drop), 64'd0);
        rst = 1'b0;

        // Known ramp: natural order comes out as 0,4,2,6,1,5,3,7.
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 32'(i);
            fr_im[i] = 32'(100 + i);
        end
        expect_frame();
        base = got_q.size();
        send_frame(0);
        drain("ramp", 1'b1);
        first_cyc = (got_q.size() > base) ? got_q[base].cyc : 32'hFFFF_FFFF;
        end_cyc   = (got_q.size() >= base + N) ? got_q[base+N-1].cyc : 32'hFFFF_FFFF;
        check("ramp start latency", 64'(first_cyc), 64'(last_acc + 1));
        check("ramp end latency", 64'(end_cyc), 64'(last_acc + N));

        d0 = drop_seen;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            expect_frame();
            send_frame(0);
        end
        drain("b2b", 1'b1);
        check("b2b drops", 64'(drop_seen - d0), 64'd0);

        rand_frame();
        expect_frame();
        send_frame(1);
        drain("gapped", 1'b1);

        e0 = err_seen;
        rand_frame();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, i == 4, fr_re[i], fr_im[i]);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("short err", 64'(err_seen - e0), 64'd1);
        drain("short none", 1'b0);
        rand_frame();
        expect_frame();
        send_frame(0);
        drain("after short", 1'b1);

        e0 = err_seen;
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, $urandom, $urandom);
        rand_frame();
        expect_frame();
        send_frame(0);
        drain("restart", 1'b1);
        check("restart err", 64'(err_seen - e0), 64'd1);

        rand_frame();
        send_frame(0);
        repeat (3) @(posedge clk);
        #1;
        check("pre-rst busy", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst out_end", 64'(out_end), 64'd0);
        rst = 1'b0;
        got_rd = got_q.size();
        rand_frame();
        expect_frame();
        send_frame(0);
        drain("after rst", 1'b1);

        check("no drops", 64'(drop_seen), 64'd0);
        check("no stray flags", 64'(stray_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
